stream_demux_n_bit: RTL and testbench

STREAM_DEMUX_N_BIT -- requirements
Module: stream_demux_n_bit

---
 rtl/stream_demux_n_bit.sv | 72 +++++++
 tb/tb_stream_demux_n_bit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stream_demux_n_bit.sv
// 1-to-2 stream demultiplexer: one registered slot per channel, routed by
// control, with a per-channel wrap-around count of words delivered.
module stream_demux_n_bit #(
  parameter int N  = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  input  logic          control,
  output logic          in_ready,
  output logic [N-1:0]  out0_data,
  output logic [N-1:0]  out1_data,
  output logic          out0_valid,
  output logic          out1_valid,
  input  logic          out0_ready,
  input  logic          out1_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  logic [1:0][N-1:0]  data_q, data_d;
  logic [1:0]         valid_q, valid_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         out_ready;
  logic [1:0]         drain;
  logic [1:0]         load;
  logic               accept;

  always_comb begin
    out_ready = {out1_ready, out0_ready};
    drain     = valid_q & out_ready;
    // Only the selected slot gates acceptance; a draining slot frees itself this edge.
    in_ready  = ~valid_q[control] | out_ready[control];
    accept    = in_valid & in_ready;
    load      = {accept & control, accept & ~control};
    data_d    = data_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    for (int unsigned k = 0; k < 2; k++) begin
      if (drain[k]) begin
        valid_d[k] = 1'b0;
        cnt_d[k]   = cnt_q[k] + CW'(1);
      end
      if (load[k]) begin
        data_d[k]  = in_data;
        valid_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign out0_valid = valid_q[0];
  assign out1_valid = valid_q[1];
  assign cnt0       = cnt_q[0];
  assign cnt1       = cnt_q[1];

endmodule

// File: tb/tb_stream_demux_n_bit.sv
// Bench for stream_demux_n_bit: directed scenarios plus random traffic,
// compared against a queue-based model of the two channels.
module tb_stream_demux_n_bit;
  localparam int N  = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          control;
  logic          in_ready;
  logic [N-1:0]  out0_data, out1_data;
  logic          out0_valid, out1_valid;
  logic          out0_ready, out1_ready;
  logic [CW-1:0] cnt0, cnt1;

  stream_demux_n_bit #(.N(N), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .control(control), .in_ready(in_ready),
    .out0_data(out0_data), .out1_data(out1_data),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_ready(out0_ready), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pending words per channel, last word loaded, delivered count.
  logic [N-1:0] m0[$], m1[$];
  logic [N-1:0] l0, l1;
  int c0, c1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m0.delete(); m1.delete();
    l0 = '0; l1 = '0; c0 = 0; c1 = 0;
  endtask

  task automatic check_outputs();
    check("out0_valid", 64'(out0_valid), 64'(m0.size() != 0));
    check("out1_valid", 64'(out1_valid), 64'(m1.size() != 0));
    check("out0_data", 64'(out0_data), 64'(l0));
    check("out1_data", 64'(out1_data), 64'(l1));
    check("cnt0", 64'(cnt0), 64'(c0));
    check("cnt1", 64'(cnt1), 64'(c1));
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic v, input logic ctrl, input logic [N-1:0] d,
                      input logic r0, input logic r1);
    logic exp_rdy, acc;
    in_valid = v; control = ctrl; in_data = d; out0_ready = r0; out1_ready = r1;
    #3;
    exp_rdy = ctrl ? (m1.size() == 0 || r1) : (m0.size() == 0 || r0);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    if (m0.size() != 0 && r0) begin void'(m0.pop_front()); c0 = (c0 + 1) % (1 << CW); end
    if (m1.size() != 0 && r1) begin void'(m1.pop_front()); c1 = (c1 + 1) % (1 << CW); end
    if (acc) begin
      if (ctrl) begin m1.push_back(d); l1 = d; end
      else      begin m0.push_back(d); l0 = d; end
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  // Reset asserted between edges, checked before any clock edge occurs.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_clear();
    check("rst_out0_valid", 64'(out0_valid), 64'd0);
    check("rst_out1_valid", 64'(out1_valid), 64'd0);
    check("rst_out0_data", 64'(out0_data), 64'd0);
    check("rst_out1_data", 64'(out1_data), 64'd0);
    check("rst_cnt0", 64'(cnt0), 64'd0);
    check("rst_cnt1", 64'(cnt1), 64'd0);
    in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    control = 1'b0; #1;
    check("rdy_after_rst_c0", 64'(in_ready), 64'd1);
    control = 1'b1; #1;
    check("rdy_after_rst_c1", 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; control = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    model_clear();
    #12;
    check_outputs();
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic routing, first word on the first edge after reset release.
    step(1, 0, 32'hA5A5_0001, 1, 1);
    check("route_out0", 64'(out0_data), 64'hA5A5_0001);
    step(1, 1, 32'h0000_BEEF, 1, 1);
    check("route_out1", 64'(out1_data), 64'h0000_BEEF);
    step(0, 0, 32'h0, 1, 1);
    check("route_cnt0", 64'(cnt0), 64'd1);
    check("route_cnt1", 64'(cnt1), 64'd1);

    // Backpressure on channel 1, then drain and reload on the same edge.
    step(1, 1, 32'h11, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 32'h22, 1, 0);
    check("bp_hold", 64'(out1_data), 64'h11);
    step(1, 1, 32'h22, 1, 1);
    check("bp_reload_data", 64'(out1_data), 64'h22);
    check("bp_reload_valid", 64'(out1_valid), 64'd1);

    // Channel independence with channel 1 full and stalled.
    async_reset();
    step(1, 1, 32'hC1C1_C1C1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 32'h100 + i, 1, 0);
    step(0, 0, 32'h0, 1, 0);
    check("indep_cnt0", 64'(cnt0), 64'd4);
    check("indep_out1", 64'(out1_data), 64'hC1C1_C1C1);
    check("indep_v1", 64'(out1_valid), 64'd1);

    // Counter wrap on channel 0.
    async_reset();
    for (int i = 0; i < 257; i++) step(1, 0, $urandom, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    check("wrap_cnt0", 64'(cnt0), 64'd1);
    check("wrap_cnt1", 64'(cnt1), 64'd0);

    // Async reset with both slots holding words.
    step(1, 0, 32'hDEAD_0000, 0, 0);
    step(1, 1, 32'hDEAD_0001, 0, 0);
    async_reset();
    step(0, 0, 32'h0, 1, 1);

    // Idle input with toggling control and data.
    step(1, 1, 32'h77, 1, 1);
    step(0, 0, 32'h0, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 1'(i), $urandom, 1'($urandom), 1'($urandom));
    check("idle_v0", 64'(out0_valid), 64'd0);
    check("idle_v1", 64'(out1_valid), 64'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    async_reset();
    for (int i = 0; i < 100; i++)
      step(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
